// File: rtl/framebuffer_scanout.sv
// Double-buffered 1-bit framebuffer with raster scanout and a vblank buffer-swap handshake.
// Optional: define FB_BORDER_EN to overlay a 1-pixel debug outline on the active area.
module framebuffer_scanout #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int HOR_FRONT_PORCH   = 16,
  parameter int HOR_SYNC          = 96,
  parameter int HOR_BACK_PORCH    = 48,
  parameter int VER_FRONT_PORCH   = 10,
  parameter int VER_SYNC          = 2,
  parameter int VER_BACK_PORCH    = 33,
  // One extra code point so an address equal to H*V stays representable when H*V is a power of two.
  localparam int AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          render_done,
  output logic          swap,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          pixel,
  output logic          front_sel
);

  localparam int H       = HOR_ACTIVE_PIXELS;
  localparam int V       = VER_ACTIVE_PIXELS;
  localparam int H_TOTAL = H + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = V + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int HS_BEG  = H + HOR_FRONT_PORCH;
  localparam int HS_END  = HS_BEG + HOR_SYNC;
  localparam int VS_BEG  = V + VER_FRONT_PORCH;
  localparam int VS_END  = VS_BEG + VER_SYNC;
  localparam int DEPTH   = H * V;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int IW      = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, NOTIFY = 1'b1} state_t;

  state_t        state, state_next;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, blank_start, act, hs_raw, vs_raw;
  logic [IW-1:0] addr1;
  logic          de1, hs1, vs1;
  logic          mem0 [DEPTH];
  logic          mem1 [DEPTH];
  logic          rd_bit, pix_next, swap_next, toggle;

  assign h_last      = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last      = (int'(v_cnt) == V_TOTAL - 1);
  assign blank_start = h_last && (int'(v_cnt) == V - 1);
  assign act         = (int'(h_cnt) < H) && (int'(v_cnt) < V);
  assign hs_raw      = !((int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END));
  assign vs_raw      = !((int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr1 <= '0;
      de1   <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else if (ce) begin
      addr1 <= act ? IW'(int'(v_cnt) * H + int'(h_cnt)) : '0;
      de1   <= act;
      hs1   <= hs_raw;
      vs1   <= vs_raw;
    end
  end

`ifdef FB_BORDER_EN
  logic [HW-1:0] x1;
  logic [VW-1:0] y1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1 <= '0;
      y1 <= '0;
    end else if (ce) begin
      x1 <= h_cnt;
      y1 <= v_cnt;
    end
  end
`endif

  // Writes always target the buffer that is not being scanned, as seen before this edge.
  always_ff @(posedge clk) begin
    if (ce && wr_en && (int'(wr_addr) < DEPTH)) begin
      if (front_sel) mem0[wr_addr[IW-1:0]] <= wr_data;
      else           mem1[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  assign rd_bit = front_sel ? mem1[addr1] : mem0[addr1];

  always_comb begin
    pix_next = 1'b0;
    if (de1) begin
      pix_next = rd_bit;
`ifdef FB_BORDER_EN
      if ((int'(x1) == 0) || (int'(x1) == H - 1) || (int'(y1) == 0) || (int'(y1) == V - 1))
        pix_next = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      pixel <= 1'b0;
    end else if (ce) begin
      de    <= de1;
      hsync <= hs1;
      vsync <= vs1;
      pixel <= pix_next;
    end
  end

  // Swap only at the first blanking line, so the front buffer never changes mid-frame.
  always_comb begin
    state_next = state;
    swap_next  = swap;
    toggle     = 1'b0;
    case (state)
      IDLE: begin
        if (ce && blank_start && render_done) begin
          state_next = NOTIFY;
          swap_next  = 1'b1;
          toggle     = 1'b1;
        end
      end
      NOTIFY: begin
        if (ce) begin
          state_next = IDLE;
          swap_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        swap_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      swap      <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      state     <= state_next;
      swap      <= swap_next;
      front_sel <= front_sel ^ toggle;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on an 8x4 raster with 1-pixel porches/syncs (11 x 7 total).
module tb_framebuffer_scanout;

  logic       clk = 1'b0;
  logic       rst, ce, wr_en, wr_data, render_done;
  logic [5:0] wr_addr;
  logic       swap, hsync, vsync, de, pixel, front_sel;
  int         errors = 0;
  int         checks = 0;
  int         tk = 0;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(4),
    .HOR_FRONT_PORCH(1), .HOR_SYNC(1), .HOR_BACK_PORCH(1),
    .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .render_done(render_done), .swap(swap), .hsync(hsync), .vsync(vsync), .de(de),
    .pixel(pixel), .front_sel(front_sel)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (tick %0d)", tag, obs, expv, tk);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected raster values for scan position p (index into the 77-tick frame).
  function automatic logic exp_de(input int p);
    return ((p % 11) < 8) && (((p / 11) % 7) < 4);
  endfunction

  function automatic logic exp_hs(input int p);
    return (p % 11) != 9;
  endfunction

  function automatic logic exp_vs(input int p);
    return ((p / 11) % 7) != 5;
  endfunction

  function automatic logic exp_pix(input int p, input logic [31:0] img);
    int  h;
    int  v;
    logic b;
    h = p % 11;
    v = (p / 11) % 7;
    if (!((h < 8) && (v < 4))) return 1'b0;
    b = img[v * 8 + h];
`ifdef FB_BORDER_EN
    if ((h == 0) || (h == 7) || (v == 0) || (v == 3)) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (ce) tk++;
    @(negedge clk);
  endtask

  task automatic write_img(input logic [31:0] img);
    for (int a = 0; a < 32; a++) begin
      wr_en   = 1'b1;
      wr_addr = 6'(a);
      wr_data = img[a];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_swap(input string tag);
    int n;
    n = 0;
    while (swap !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, swap, 1'b1);
  endtask

  task automatic run_to(input int idx);
    int n;
    n = 0;
    while ((tk % 77) != idx && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Outputs after tick tk describe counter position tk-2 (two ce ticks of latency).
  task automatic scan(input int n, input logic [31:0] img, input logic fs);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("de", de, exp_de(tk - 2));
      chk("hsync", hsync, exp_hs(tk - 2));
      chk("vsync", vsync, exp_vs(tk - 2));
      chk("pixel", pixel, exp_pix(tk - 2, img));
      chk("swap_idle", swap, 1'b0);
      chk("front_sel", front_sel, fs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   de_n, hs_n, vs_n, rises, toggles, high, coincide, ce_rise;
    logic pf, ps;

    rst = 1'b1; ce = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 1'b0; render_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_de", de, 1'b0);
    chk("rst_pixel", pixel, 1'b0);
    chk("rst_swap", swap, 1'b0);
    chk("rst_front", front_sel, 1'b0);

    // Raster timing over one full frame, no swap requested.
    rst = 1'b0;
    tk  = 0;
    tick();
    chk("de_tick1", de, 1'b0);
    chk("hsync_tick1", hsync, 1'b1);
    de_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 77; i++) begin
      tick();
      chk("de_t", de, exp_de(tk - 2));
      chk("hsync_t", hsync, exp_hs(tk - 2));
      chk("vsync_t", vsync, exp_vs(tk - 2));
      if (de) de_n++;
      if (!hsync) hs_n++;
      if (!vsync) vs_n++;
    end
    chk_n("de_per_frame", de_n, 32);
    chk_n("hsync_low_per_frame", hs_n, 7);
    chk_n("vsync_low_per_frame", vs_n, 11);

    // Clear both buffers through two swaps.
    write_img(32'h0);
    render_done = 1'b1;
    wait_swap("swap_b1");
    render_done = 1'b0;
    chk("front_b1", front_sel, 1'b1);
    tick();
    chk("swap_clear_b1", swap, 1'b0);
    write_img(32'h0);
    render_done = 1'b1;
    wait_swap("swap_b2");
    render_done = 1'b0;
    chk("front_b2", front_sel, 1'b0);
    tick();
    chk("swap_clear_b2", swap, 1'b0);

    // Renderer never ready: back-buffer writes must stay invisible for 3 frames.
    write_img(32'hFFFF_FFFF);
    scan(231, 32'h0, 1'b0);

    // Single lit pixel at (5,0) after a swap.
    write_img(32'h0000_0020);
    render_done = 1'b1;
    wait_swap("swap_c");
    render_done = 1'b0;
    chk("front_c", front_sel, 1'b1);
    scan(77, 32'h0000_0020, 1'b1);

    // Handshake with ce on every second clock.
    run_to(50);
    render_done = 1'b1;
    rises = 0; toggles = 0; high = 0; coincide = 0; ce_rise = 0;
    pf = front_sel;
    ps = swap;
    for (int i = 0; i < 308; i++) begin
      ce = (i % 2) == 1;
      tick();
      if (swap && !ps) begin
        rises++;
        if (ce) ce_rise++;
      end
      if (front_sel != pf) begin
        toggles++;
        if (swap && !ps) coincide++;
      end
      if (swap) high++;
      pf = front_sel;
      ps = swap;
    end
    ce = 1'b1;
    render_done = 1'b0;
    chk_n("hs_swap_rises", rises, 2);
    chk_n("hs_front_toggles", toggles, 2);
    chk_n("hs_swap_high_clks", high, 4);
    chk_n("hs_toggle_with_swap", coincide, 2);
    chk_n("hs_rise_on_ce", ce_rise, 2);
    chk("hs_front_end", front_sel, 1'b1);

    // Out-of-range write, then a write on the toggle tick itself.
    wr_en = 1'b1; wr_addr = 6'd32; wr_data = 1'b1;
    repeat (3) tick();
    wr_en = 1'b0;
    render_done = 1'b1;
    run_to(43);
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 1'b1;
    tick();
    wr_en = 1'b0;
    render_done = 1'b0;
    chk("swap_f", swap, 1'b1);
    chk("front_f", front_sel, 1'b0);
    scan(77, 32'h0000_0400, 1'b0);

    // Asynchronous reset mid-line at (3,2) with front_sel=1.
    render_done = 1'b1;
    wait_swap("swap_g");
    render_done = 1'b0;
    chk("front_g", front_sel, 1'b1);
    run_to(25);
    chk("de_before_rst", de, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hsync", hsync, 1'b1);
    chk("arst_vsync", vsync, 1'b1);
    chk("arst_de", de, 1'b0);
    chk("arst_swap", swap, 1'b0);
    chk("arst_front", front_sel, 1'b0);
    chk("arst_pixel", pixel, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tk  = 0;
    tick();
    chk("de_after_rst", de, 1'b0);
    scan(77, 32'h0000_0400, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
